mem_arbiter: RTL and testbench

- Shares one single-ported, multi-cycle memory between the instruction-fetch port and the data-memory port of the pipeline.
- The arbiter sequences each access through a small FSM and latches the request.
- It drives the memory and returns a one-cycle done pulse with the read data.
- Data accesses normally win; a starvation counter guarantees that fetch makes forward progress.

---
 rtl/mem_arb_defs.sv | 20 ++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_defs.sv
// Shared definitions for the instruction/data memory arbiter: FSM encoding,
// default limits and counter sizing.
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 15;

  // Bits needed to hold a counter that reaches n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for a free memory: data wins unless fetch has waited through
// STARVE_MAX data grants; also yields the starvation count after this grant.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4,
  parameter int W          = 3
) (
  input  logic         if_req,
  input  logic         dm_req,
  input  logic [W-1:0] starve_cnt,
  output logic         grant_i,
  output logic         grant_d,
  output logic [W-1:0] starve_next
);

  logic starved;

  assign starved = (starve_cnt >= W'(STARVE_MAX));

  always_comb begin
    grant_d     = dm_req && !(if_req && starved);
    grant_i     = if_req && !grant_d;
    // A data grant over a waiting fetch can only happen below the limit,
    // so the increment never overflows the saturation point.
    starve_next = (grant_d && if_req) ? starve_cnt + W'(1) : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle single-port memory between fetch and data ports,
// one latched access at a time, with a done pulse and sticky timeout error.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  localparam int SW = cnt_width(STARVE_MAX);
  localparam int TW = cnt_width(TIMEOUT);

  arb_state_t    state_reg, state_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [TW-1:0] tmo_reg;
  logic [15:0]   addr_reg, wdata_reg, if_rdata_reg, dm_rdata_reg;
  logic          wr_reg, owner_d_reg, err_reg;
  logic          grant_i, grant_d, busy, tmo_hit;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .W          (SW)
  ) u_pick (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .starve_cnt  (starve_reg),
    .grant_i     (grant_i),
    .grant_d     (grant_d),
    .starve_next (starve_next)
  );

  assign busy    = (state_reg == BUSY_I) || (state_reg == BUSY_D);
  // Fires on the TIMEOUT-th busy cycle; a late mem_done still takes priority.
  assign tmo_hit = busy && !mem_done && (tmo_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d)      state_next = BUSY_D;
        else if (grant_i) state_next = BUSY_I;
      end
      BUSY_I, BUSY_D: if (mem_done || tmo_hit) state_next = RESP;
      RESP:           state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_done   = 1'b0;
    dm_done   = 1'b0;
    case (state_reg)
      BUSY_I: begin
        mem_en    = 1'b1;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
      end
      BUSY_D: begin
        mem_en    = 1'b1;
        mem_wr    = wr_reg;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
      end
      RESP: begin
        if_done = !owner_d_reg;
        dm_done = owner_d_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wr_reg       <= 1'b0;
      owner_d_reg  <= 1'b0;
      starve_reg   <= '0;
      tmo_reg      <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (grant_i || grant_d) begin
          addr_reg    <= grant_d ? dm_addr : if_addr;
          wdata_reg   <= grant_d ? dm_wdata : 16'h0000;
          wr_reg      <= grant_d && dm_wr;
          owner_d_reg <= grant_d;
          starve_reg  <= starve_next;
          tmo_reg     <= '0;
        end
        BUSY_I, BUSY_D: begin
          tmo_reg <= tmo_reg + TW'(1);
          if (mem_done) begin
            if (state_reg == BUSY_I) if_rdata_reg <= mem_rdata;
            else if (!wr_reg)        dm_rdata_reg <= mem_rdata;
          end else if (tmo_hit) begin
            err_reg <= 1'b1;
            if (state_reg == BUSY_I) if_rdata_reg <= 16'h0000;
            else                     dm_rdata_reg <= 16'h0000;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_rdata = if_rdata_reg;
  assign dm_rdata = dm_rdata_reg;
  assign err      = err_reg;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter: fixed-latency memory device
// plus a reference of memory contents, grant order and sticky error.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 15;
  localparam int LAT        = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done, if_stall;
  logic [15:0] if_addr, if_rdata;
  logic        dm_req, dm_wr, dm_done, dm_stall;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_wr, mem_done, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          hang     = 1'b0;
  bit          err_exp  = 1'b0;
  int          d_wins   = 0;
  logic [15:0] ref_mem [0:255];

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  // Memory device: completes LAT cycles after mem_en rises unless hung.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hABCD : {a, ~a};
  endfunction

  logic [15:0] mem_arr [0:255];
  bit          written [0:255];
  int          lat_cnt;

  assign mem_done  = mem_en && !hang && (lat_cnt == LAT - 1);
  assign mem_rdata = !mem_done ? 16'h0000 :
                     (written[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : init_val(mem_addr[7:0]));

  always @(posedge clk or posedge rst) begin
    if (rst)                    lat_cnt <= 0;
    else if (mem_en && !mem_done) lat_cnt <= lat_cnt + 1;
    else                        lat_cnt <= 0;
  end

  always @(posedge clk) begin
    if (mem_done && mem_wr) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated access on one port; checks bus, latency, done port, data, err.
  task automatic access(input bit is_d, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input string tag);
    int c, bad, exp_lat;
    logic [15:0] old_dm, old_if, exp_rd, got_rd, bad_addr;
    old_dm  = dm_rdata;
    old_if  = if_rdata;
    exp_lat = hang ? TIMEOUT + 1 : LAT + 1;
    bad     = 0;
    bad_addr = '0;
    if (is_d) begin
      dm_addr = addr; dm_wr = wr; dm_wdata = wdata; dm_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    for (c = 1; c <= 40; c++) begin
      tick();
      if (if_done || dm_done) break;
      if (mem_en !== 1'b1 || mem_addr !== addr || mem_wr !== (is_d && wr) ||
          (is_d && wr && mem_wdata !== wdata) || (is_d ? dm_stall : if_stall) !== 1'b1) begin
        bad++;
        bad_addr = mem_addr;
      end
      // Requester inputs wander while busy; the latched access must not.
      if (is_d) begin
        dm_addr = addr ^ 16'h0089; dm_wdata = ~wdata; dm_wr = ~wr;
      end else begin
        if_addr = addr ^ 16'h0089;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_bus %s: %0d bad busy cycles, mem_addr=%h required %h", tag, bad, bad_addr, addr);
    end
    n_checks++;
    if (c != exp_lat) begin
      n_fail++;
      $display("FAIL latency %s: done at cycle %0d, required %0d", tag, c, exp_lat);
    end
    n_checks++;
    if (dm_done !== is_d || if_done !== !is_d) begin
      n_fail++;
      $display("FAIL done_port %s: if_done=%b dm_done=%b, required dm_done=%b", tag, if_done, dm_done, is_d);
    end
    n_checks++;
    if (mem_en !== 1'b0 || (is_d ? dm_stall : if_stall) !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_bus %s: mem_en=%b stall=%b, required 0 0", tag, mem_en, is_d ? dm_stall : if_stall);
    end
    exp_rd = hang ? 16'h0000 : ((is_d && wr) ? old_dm : ref_mem[addr[7:0]]);
    got_rd = is_d ? dm_rdata : if_rdata;
    n_checks++;
    if (got_rd !== exp_rd) begin
      n_fail++;
      $display("FAIL rdata %s: got %h, required %h", tag, got_rd, exp_rd);
    end
    n_checks++;
    if ((is_d ? if_rdata : dm_rdata) !== (is_d ? old_if : old_dm)) begin
      n_fail++;
      $display("FAIL other_rdata %s: got %h, required %h", tag,
               is_d ? if_rdata : dm_rdata, is_d ? old_if : old_dm);
    end
    if (hang) err_exp = 1'b1;
    n_checks++;
    if (err !== err_exp) begin
      n_fail++;
      $display("FAIL err %s: got %b, required %b", tag, err, err_exp);
    end
    if (is_d && wr && !hang) ref_mem[addr[7:0]] = wdata;
    d_wins = 0;
    $display("txn %s: port=%s wr=%0b addr=%h rdata=%h lat=%0d err=%b", tag,
             is_d ? "D" : "I", wr, addr, got_rd, c, err);
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
  endtask

  // Both ports request continuously; grants must follow the starvation rule.
  task automatic run_contention(input int n, input string tag);
    int c, exp_c;
    bit exp_d;
    logic [15:0] ia, da, r;
    r = 16'($urandom); ia = {r[15:8], 8'h50 | {6'h0, r[1:0]}};
    r = 16'($urandom); da = {r[15:8], 8'h60 | {6'h0, r[1:0]}};
    if_addr = ia; dm_addr = da; dm_wr = 1'b0; if_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_d = (d_wins < STARVE_MAX);
      exp_c = (k == 0) ? LAT + 1 : LAT + 2;
      for (c = 1; c <= 20; c++) begin
        tick();
        if (if_done || dm_done) break;
      end
      n_checks++;
      if (dm_done !== exp_d || if_done !== !exp_d) begin
        n_fail++;
        $display("FAIL grant %s #%0d: if_done=%b dm_done=%b, required dm_done=%b", tag, k, if_done, dm_done, exp_d);
      end
      n_checks++;
      if (c != exp_c) begin
        n_fail++;
        $display("FAIL grant_lat %s #%0d: %0d cycles, required %0d", tag, k, c, exp_c);
      end
      n_checks++;
      if ((exp_d ? dm_rdata : if_rdata) !== ref_mem[exp_d ? da[7:0] : ia[7:0]]) begin
        n_fail++;
        $display("FAIL grant_rdata %s #%0d: got %h, required %h", tag, k,
                 exp_d ? dm_rdata : if_rdata, ref_mem[exp_d ? da[7:0] : ia[7:0]]);
      end
      $display("txn %s #%0d: grant=%s if_done=%b dm_done=%b", tag, k, exp_d ? "D" : "I", if_done, dm_done);
      if (exp_d) begin
        d_wins++;
        da = da + 16'h0001; dm_addr = da;
      end else begin
        d_wins = 0;
        ia = ia + 16'h0001; if_addr = ia;
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    tick(); tick();
    n_checks++;
    if ({if_done, dm_done, mem_en, mem_wr, err, if_stall, dm_stall, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b wr=%b addr=%h wdata=%h done=%b%b err=%b rdata=%h/%h, required all 0",
               mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done, err, if_rdata, dm_rdata);
    end
    rst = 1'b0;
    tick();
    $display("txn reset: outputs idle");
  endtask

  task automatic test_single_fetch();
    access(1'b0, 1'b0, 16'h0010, 16'h0000, "single_fetch");
  endtask

  task automatic test_write_read();
    access(1'b1, 1'b1, 16'h0020, 16'h1234, "data_write");
    access(1'b1, 1'b0, 16'h0020, 16'h0000, "data_read");
  endtask

  task automatic test_random();
    logic [15:0] r, w;
    bit is_d, wr;
    for (int i = 0; i < 12; i++) begin
      r    = 16'($urandom);
      w    = 16'($urandom);
      is_d = 1'($urandom % 2);
      wr   = is_d && 1'($urandom % 2);
      access(is_d, wr, {r[15:8], 6'h10, r[1:0]}, w, "random");
    end
  endtask

  task automatic test_timeout();
    hang = 1'b1;
    access(1'b1, 1'b0, 16'h0030, 16'h0000, "timeout");
    hang = 1'b0;
    access(1'b1, 1'b0, 16'h0031, 16'h0000, "after_timeout");
  endtask

  task automatic test_reset_mid();
    run_contention(2, "pre_reset");
    dm_addr = 16'h0070; dm_wr = 1'b1; dm_wdata = 16'h5555; dm_req = 1'b1; if_req = 1'b1;
    tick(); tick();
    n_checks++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: mem_en=%b mem_wr=%b, required 1 1", mem_en, mem_wr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({if_done, dm_done, mem_en, mem_wr, err, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: en=%b wr=%b addr=%h wdata=%h err=%b rdata=%h/%h, required all 0",
               mem_en, mem_wr, mem_addr, mem_wdata, err, if_rdata, dm_rdata);
    end
    $display("txn reset_mid: asserted during BUSY_D");
    if_req = 1'b0; dm_req = 1'b0;
    d_wins = 0; err_exp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    run_contention(5, "post_reset");
    access(1'b0, 1'b0, 16'h0010, 16'h0000, "fresh_fetch");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    test_reset();
    test_single_fetch();
    test_write_read();
    test_random();
    run_contention(10, "contention");
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
